survivor_traceback: RTL and testbench

//  Viterbi survivor-memory and traceback stage, directly downstream of the radix-4 ACS.

---
 rtl/survivor_traceback_pkg.sv | 20 ++
 rtl/survivor_traceback_if.sv | 23 ++
 rtl/survivor_traceback_ram.sv | 22 ++
 rtl/survivor_traceback.sv | 107 ++++++++++
 tb/tb_survivor_traceback.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/survivor_traceback_pkg.sv
// Shared sizing and types for the Viterbi survivor-memory / traceback stage.
package survivor_traceback_pkg;
  localparam int MAX_STATE_NUM = 256;
  localparam int STATE_W       = 8;
  localparam int SYM_W         = 2;
  localparam int FRAME_LEN     = 64;
  localparam int CNT_W         = $clog2(FRAME_LEN);

  typedef logic [STATE_W-1:0]          state_t;
  typedef logic [SYM_W-1:0]            sym_t;
  typedef logic [CNT_W-1:0]            cnt_t;
  typedef state_t [MAX_STATE_NUM-1:0]  column_t;

  typedef enum logic [1:0] {TB_IDLE, TB_FILL, TB_TRACE, TB_DRAIN} tb_state_e;

  // The ACS packs a step's two input bits LSB-first into the state index.
  function automatic sym_t state_to_sym(input state_t st);
    return {st[0], st[1]};
  endfunction
endpackage

// File: rtl/survivor_traceback_if.sv
// Survivor-column input stream and decoded-symbol output stream of the traceback stage.
interface survivor_traceback_if;
  import survivor_traceback_pkg::*;

  logic    i_valid;
  logic    o_ready;
  column_t i_fwd_prv_st;
  state_t  i_sel_node;
  logic    i_last;
  sym_t    o_data;
  logic    o_valid;
  logic    i_ready;

  modport master (
    output i_valid, i_fwd_prv_st, i_sel_node, i_last, i_ready,
    input  o_ready, o_data, o_valid
  );

  modport slave (
    input  i_valid, i_fwd_prv_st, i_sel_node, i_last, i_ready,
    output o_ready, o_data, o_valid
  );
endinterface

// File: rtl/survivor_traceback_ram.sv
// Survivor memory: one full column written per step, state-indexed asynchronous read.
module survivor_traceback_ram
  import survivor_traceback_pkg::*;
(
  input  logic    clk,
  input  logic    i_we,
  input  cnt_t    i_waddr,
  input  column_t i_wdata,
  input  cnt_t    i_raddr,
  input  state_t  i_rstate,
  output state_t  o_prev
);

  column_t r_mem [FRAME_LEN];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_prev = r_mem[i_raddr][i_rstate];

endmodule

// File: rtl/survivor_traceback.sv
// Viterbi traceback: stores survivor columns, traces back from the best node at
// frame end, then streams the recovered symbols out in time order.
module survivor_traceback
  import survivor_traceback_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  survivor_traceback_if.slave   bus,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  tb_state_e r_state;
  cnt_t      r_wr_cnt;
  cnt_t      r_col;
  cnt_t      r_rd_ptr;
  cnt_t      r_last_col;
  state_t    r_cur_st;
  logic      r_o_valid;
  logic      r_frame_done;
  sym_t      r_sym_mem [FRAME_LEN];

  logic      w_accept;
  logic      w_frame_end;
  logic      w_trace;
  state_t    w_prev_st;

  assign bus.o_ready  = (r_state == TB_IDLE) || (r_state == TB_FILL);
  assign o_busy       = (r_state == TB_TRACE) || (r_state == TB_DRAIN);
  assign w_accept     = bus.i_valid && bus.o_ready;
  assign w_frame_end  = bus.i_last || (r_wr_cnt == cnt_t'(FRAME_LEN - 1));
  assign w_trace      = (r_state == TB_TRACE);
  assign bus.o_valid  = r_o_valid;
  assign bus.o_data   = r_sym_mem[r_rd_ptr];
  assign o_frame_done = r_frame_done;

  survivor_traceback_ram u_ram (
    .clk      (clk),
    .i_we     (w_accept),
    .i_waddr  (r_wr_cnt),
    .i_wdata  (bus.i_fwd_prv_st),
    .i_raddr  (r_col),
    .i_rstate (r_cur_st),
    .o_prev   (w_prev_st)
  );

  // Symbol store is filled back-to-front during traceback and is not reset.
  always_ff @(posedge clk) begin
    if (w_trace) r_sym_mem[r_col] <= state_to_sym(r_cur_st);
  end

  // r_last_col holds n_col-1: it is both the traceback start and the drain end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= TB_IDLE;
      r_wr_cnt     <= '0;
      r_col        <= '0;
      r_rd_ptr     <= '0;
      r_last_col   <= '0;
      r_cur_st     <= '0;
      r_o_valid    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        TB_IDLE, TB_FILL: begin
          if (w_accept) begin
            if (w_frame_end) begin
              r_last_col <= r_wr_cnt;
              r_col      <= r_wr_cnt;
              r_cur_st   <= bus.i_sel_node;
              r_state    <= TB_TRACE;
            end else begin
              r_wr_cnt <= r_wr_cnt + 1'b1;
              r_state  <= TB_FILL;
            end
          end
        end
        TB_TRACE: begin
          r_cur_st <= w_prev_st;
          if (r_col == '0) begin
            r_state   <= TB_DRAIN;
            r_rd_ptr  <= '0;
            r_o_valid <= 1'b1;
          end else begin
            r_col <= r_col - 1'b1;
          end
        end
        TB_DRAIN: begin
          if (r_o_valid && bus.i_ready) begin
            if (r_rd_ptr == r_last_col) begin
              r_state      <= TB_IDLE;
              r_o_valid    <= 1'b0;
              r_wr_cnt     <= '0;
              r_rd_ptr     <= '0;
              r_frame_done <= 1'b1;
            end else begin
              r_rd_ptr <= r_rd_ptr + 1'b1;
            end
          end
        end
        default: r_state <= TB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_survivor_traceback.sv
// Bench for survivor_traceback: frames come from a shift-register trellis encoder
// model, so the decoded stream must reproduce the encoder's input symbols.
module tb_survivor_traceback;
  import survivor_traceback_pkg::*;

  typedef struct {
    sym_t sym;
    bit   last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  logic frameDone;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   doneCount = 0;
  int   readyMode = 0;
  int   acceptCyc = 0;
  int   firstValidCyc = 0;
  bit   pendingDone = 0;
  logic prevValid = 1'b0;
  exp_t expQ [$];

  survivor_traceback_if bus ();

  survivor_traceback dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .o_busy       (busy),
    .o_frame_done (frameDone)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input bit ok, input string name, input int actual, input int expected);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Downstream ready pattern: 0 always, 1 toggling, 2 random, else stalled.
  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       bus.i_ready = 1'b1;
        1:       bus.i_ready = ~bus.i_ready;
        2:       bus.i_ready = 1'($urandom_range(0, 1));
        default: bus.i_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer, checks held data while stalled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (pendingDone) begin
          checkOutput(frameDone == 1'b1, "frame_done_pulse", int'(frameDone), 1);
          checkOutput(bus.o_valid == 1'b0, "valid_after_done", int'(bus.o_valid), 0);
          checkOutput(bus.o_ready == 1'b1, "ready_after_done", int'(bus.o_ready), 1);
          pendingDone = 0;
          doneCount++;
        end else if (frameDone) begin
          checkOutput(1'b0, "frame_done_spurious", 1, 0);
        end
        if (bus.o_valid && !prevValid) firstValidCyc = cyc;
        prevValid = bus.o_valid;
        if (bus.o_valid) begin
          if (expQ.size() == 0) begin
            checkOutput(1'b0, "spurious_valid", 1, 0);
          end else if (bus.i_ready) begin
            e = expQ.pop_front();
            checkOutput(bus.o_data == e.sym, "symbol", int'(bus.o_data), int'(e.sym));
            if (e.last) pendingDone = 1;
          end else begin
            checkOutput(bus.o_data == expQ[0].sym, "stall_hold", int'(bus.o_data), int'(expQ[0].sym));
          end
        end
      end else begin
        prevValid = 1'b0;
      end
    end
  end

  // Encodes u[0..n-1] from state s0; each column's survivor for the true next
  // state points back to the true previous state, all other entries are noise.
  task automatic applyStimulus(input int n, input sym_t u [FRAME_LEN], input state_t s0,
                               input bit useLast, input bit holdValid, input int gapPct);
    state_t  st;
    state_t  nx;
    column_t col;
    int      tries;
    st = s0;
    for (int k = 0; k < n; k++) expQ.push_back('{sym: u[k], last: (k == n - 1)});
    @(posedge clk);
    #1;
    for (int k = 0; k < n; k++) begin
      while (int'($urandom_range(0, 99)) < gapPct) begin
        bus.i_valid = 1'b0;
        bus.i_last  = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      nx = {st[STATE_W-3:0], u[k][0], u[k][1]};
      for (int s = 0; s < MAX_STATE_NUM; s++) col[s] = state_t'($urandom);
      col[nx] = st;
      bus.i_valid      = 1'b1;
      bus.i_fwd_prv_st = col;
      bus.i_last       = useLast && (k == n - 1);
      bus.i_sel_node   = (k == n - 1) ? nx : state_t'($urandom);
      tries = 0;
      @(negedge clk);
      while (!bus.o_ready && tries < 200) begin
        @(negedge clk);
        tries++;
      end
      if (!bus.o_ready) checkOutput(1'b0, "accept_timeout", 0, 1);
      acceptCyc = cyc;
      @(posedge clk);
      #1;
      st = nx;
    end
    if (holdValid) begin
      for (int s = 0; s < MAX_STATE_NUM; s++) col[s] = state_t'($urandom);
      bus.i_fwd_prv_st = col;
      bus.i_sel_node   = state_t'($urandom);
      bus.i_last       = 1'b1;
    end else begin
      bus.i_valid = 1'b0;
      bus.i_last  = 1'b0;
    end
  endtask

  task automatic waitDone(input int target, input int bound);
    int c;
    c = 0;
    while (doneCount < target && c < bound) begin
      @(negedge clk);
      c++;
    end
    checkOutput(doneCount >= target, "frame_done_timeout", doneCount, target);
  endtask

  task automatic resetNow();
    #2;
    rst = 1'b0;
    #1;
    checkOutput(bus.o_valid == 1'b0, "reset_valid", int'(bus.o_valid), 0);
    checkOutput(bus.o_ready == 1'b1, "reset_ready", int'(bus.o_ready), 1);
    checkOutput(busy == 1'b0, "reset_busy", int'(busy), 0);
    expQ.delete();
    pendingDone = 0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    sym_t u [FRAME_LEN];
    int   n;
    int   tgt;
    int   c;
    bit   useLast;

    bus.i_valid      = 1'b0;
    bus.i_last       = 1'b0;
    bus.i_sel_node   = '0;
    bus.i_fwd_prv_st = '0;
    for (int k = 0; k < FRAME_LEN; k++) u[k] = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput(bus.o_ready == 1'b1, "por_ready", int'(bus.o_ready), 1);
    checkOutput(bus.o_valid == 1'b0, "por_valid", int'(bus.o_valid), 0);
    checkOutput(busy == 1'b0, "por_busy", int'(busy), 0);
    checkOutput(frameDone == 1'b0, "por_frame_done", int'(frameDone), 0);
    @(negedge clk);
    #2;
    rst = 1'b1;

    $display("[TB] full-length frame, forced end at FRAME_LEN");
    for (int k = 0; k < FRAME_LEN; k++) u[k] = sym_t'(k % 4);
    tgt = doneCount + 1;
    applyStimulus(FRAME_LEN, u, '0, 1'b0, 1'b0, 0);
    waitDone(tgt, 400);
    checkOutput(firstValidCyc - acceptCyc == FRAME_LEN + 1, "latency_64", firstValidCyc - acceptCyc, FRAME_LEN + 1);

    $display("[TB] five-column frame ending in node A5");
    u[0] = 2'd3; u[1] = 2'd1; u[2] = 2'd1; u[3] = 2'd2; u[4] = 2'd2;
    tgt = doneCount + 1;
    applyStimulus(5, u, state_t'($urandom), 1'b1, 1'b0, 0);
    waitDone(tgt, 100);
    checkOutput(firstValidCyc - acceptCyc == 6, "latency_5", firstValidCyc - acceptCyc, 6);

    $display("[TB] toggling backpressure");
    for (int k = 0; k < FRAME_LEN; k++) u[k] = sym_t'($urandom);
    readyMode = 1;
    tgt = doneCount + 1;
    applyStimulus(12, u, state_t'($urandom), 1'b1, 1'b0, 0);
    waitDone(tgt, 200);
    readyMode = 0;

    $display("[TB] i_valid held through TRACE and stalled DRAIN");
    readyMode = 3;
    for (int k = 0; k < FRAME_LEN; k++) u[k] = sym_t'($urandom);
    tgt = doneCount + 1;
    applyStimulus(8, u, state_t'($urandom), 1'b1, 1'b1, 0);
    repeat (20) begin
      @(negedge clk);
      checkOutput(!bus.o_ready && busy, "ready_low_when_busy", int'(bus.o_ready), 0);
    end
    #1;
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    readyMode = 0;
    waitDone(tgt, 100);
    for (int k = 0; k < FRAME_LEN; k++) u[k] = sym_t'($urandom);
    tgt = doneCount + 1;
    applyStimulus(6, u, state_t'($urandom), 1'b1, 1'b0, 0);
    waitDone(tgt, 100);

    $display("[TB] single-column frame ending in node 02");
    u[0] = 2'b01;
    tgt = doneCount + 1;
    applyStimulus(1, u, '0, 1'b1, 1'b0, 0);
    waitDone(tgt, 50);
    checkOutput(firstValidCyc - acceptCyc == 2, "latency_1", firstValidCyc - acceptCyc, 2);

    $display("[TB] reset during TRACE");
    for (int k = 0; k < FRAME_LEN; k++) u[k] = sym_t'($urandom);
    applyStimulus(40, u, state_t'($urandom), 1'b1, 1'b0, 0);
    repeat (5) @(negedge clk);
    checkOutput(busy && !bus.o_valid, "in_trace_before_reset", int'(bus.o_valid), 0);
    resetNow();

    $display("[TB] reset during DRAIN");
    readyMode = 1;
    for (int k = 0; k < FRAME_LEN; k++) u[k] = sym_t'($urandom);
    applyStimulus(20, u, state_t'($urandom), 1'b1, 1'b0, 0);
    c = 0;
    while (expQ.size() > 10 && c < 500) begin
      @(negedge clk);
      c++;
    end
    checkOutput(expQ.size() <= 10, "drain_progress_timeout", expQ.size(), 10);
    resetNow();
    readyMode = 0;

    $display("[TB] clean frame after resets");
    for (int k = 0; k < FRAME_LEN; k++) u[k] = sym_t'($urandom);
    tgt = doneCount + 1;
    applyStimulus(10, u, state_t'($urandom), 1'b1, 1'b0, 0);
    waitDone(tgt, 100);

    $display("[TB] random frames");
    repeat (6) begin
      n = int'($urandom_range(1, FRAME_LEN));
      useLast = (n < FRAME_LEN) ? 1'b1 : 1'($urandom_range(0, 1));
      readyMode = int'($urandom_range(0, 2));
      for (int k = 0; k < FRAME_LEN; k++) u[k] = sym_t'($urandom);
      tgt = doneCount + 1;
      applyStimulus(n, u, state_t'($urandom), useLast, 1'b0, int'($urandom_range(0, 30)));
      waitDone(tgt, 600);
    end
    readyMode = 0;

    repeat (3) @(negedge clk);
    checkOutput(expQ.size() == 0, "scoreboard_empty", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
